target_segment_recorder: RTL
============================

Name: target_segment_recorder

Overview:
- Downstream consumer of the slide-window decode chain: takes per-sample target_start/target_end strobes and the sample address, pairs them into segments {start_addr, end_addr}, and buffers them in a small FIFO for host/MCU readout.
- Reports per-frame segment count and a frame-complete pulse; flags truncated segments and FIFO overflow.

Parameters:
- AW, 10, address width (matches addr bus)
- DEPTH, 8, FIFO entries (power of two)
- MIN_WIDTH, 4, minimum segment width in samples (used only with SEG_MIN_WIDTH_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- addr  in  AW  sample address of current detection result
- det_valid  in  1  target_start/target_end/addr valid this cycle (driven by upstream done)
- target_start  in  1  target leading edge at addr (qualified by det_valid)
- target_end  in  1  target trailing edge at addr (qualified by det_valid)
- frame_end  in  1  one-cycle pulse, last sample of frame has been presented
- clr  in  1  synchronous clear: FIFO, count, overflow, state
- rd_en  in  1  pop request
- rd_data  out  2*AW+1  {trunc, end_addr, start_addr} of head entry (show-ahead)
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- seg_count  out  8  segments pushed this frame (saturates 255)
- overflow  out  1  sticky: segment dropped due to full
- frame_done  out  1  one-cycle pulse when frame closed

Behaviour:
- Reset (reset=0, async): state IDLE, FIFO empty, rd_data=0, empty=1, full=0, seg_count=0, overflow=0, frame_done=0. clr=1 does the same synchronously, overriding all other inputs that cycle.
- Strobes ignored unless det_valid=1.
- FSM IDLE: target_start -> latch start_addr=addr, go OPEN. target_end alone ignored. start and end same cycle -> push {0,addr,addr} (zero-width), stay IDLE.
- FSM OPEN: target_end -> push {0,addr,start_addr}, go IDLE. target_start alone -> re-latch start_addr (restart; earlier open segment discarded). start and end same cycle -> push {0,addr,start_addr}, latch new start_addr=addr, stay OPEN.
- frame_end (any state, evaluated after strobes of same cycle): if OPEN, push {1,last valid addr,start_addr} (trunc=1); go IDLE; frame_done=1 next cycle; seg_count cleared on the cycle after frame_done (value held one cycle for capture).
- Push: 1-cycle latency, entry visible on rd_data/empty=0 the cycle after the push event. If full, entry dropped, overflow set, seg_count not incremented.
- Pop: rd_en with empty=0 advances head next cycle; rd_en on empty ignored. Simultaneous push and pop when full: pop succeeds, push accepted (no overflow).
- Pointers log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full when MSBs differ and rest equal.
- end_addr < start_addr never corrected; stored as received.

Optional Feature:
- SEG_MIN_WIDTH_EN defined: segments with (end_addr - start_addr + 1) < MIN_WIDTH (unsigned, AW+1 bits) are discarded silently, not counted, no overflow; truncated segments exempt. Undefined: all segments stored, MIN_WIDTH unused.

Test Plan:
- Reset then det_valid with start@addr=10, end@addr=25 -> rd_data={0,25,10}, empty=0, seg_count=1.
- Start@5, start@8, end@12, frame_end -> single entry {0,12,8}; frame_done pulse one cycle; seg_count=1 then 0.
- Start@900, frame_end with last addr=1023 -> entry {1,1023,900}.
- Push 9 segments with no reads (DEPTH=8) -> full=1 after 8th, overflow=1, seg_count=8; 8 pops return in order, empty=1.
- Full FIFO + simultaneous push and rd_en -> overflow stays 0, full stays 1, order preserved.
- SEG_MIN_WIDTH_EN, MIN_WIDTH=4: segments 10..12 dropped, 10..13 stored; reset asserted mid-OPEN -> all outputs to reset values immediately.

Source files
------------

// File: rtl/target_segment_recorder.sv
// Pairs qualified target_start/target_end strobes into {trunc, end_addr, start_addr} segments
// and buffers them in a show-ahead FIFO. Optional macro SEG_MIN_WIDTH_EN drops narrow segments.
module target_segment_recorder #(
   parameter int AW        = 10,
   parameter int DEPTH     = 8,
   parameter int MIN_WIDTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   addr,
   input  logic            det_valid,
   input  logic            target_start,
   input  logic            target_end,
   input  logic            frame_end,
   input  logic            clr,
   input  logic            rd_en,
   output logic [2*AW:0]   rd_data,
   output logic            empty,
   output logic            full,
   output logic [7:0]      seg_count,
   output logic            overflow,
   output logic            frame_done
);

   localparam int PW = $clog2(DEPTH) + 1;
   localparam int DW = 2*AW + 1;
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
   localparam logic [AW:0] MIN_W   = (AW+1)'(MIN_WIDTH);
`ifdef SEG_MIN_WIDTH_EN
   localparam bit MIN_EN = 1'b1;
`else
   localparam bit MIN_EN = 1'b0;
`endif

   typedef enum logic {IDLE, OPEN} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   wr_ptr, rd_ptr, used;
   logic [PW:0]     free;
   logic [PW-2:0]   wr_idx, wr_idx_b;
   logic [DW-1:0]   mem [DEPTH];
   logic [AW-1:0]   start_p1, last_p1, start_nxt, last_eff;
   logic            seg_vld_p0, trunc_vld_p0, keep_p0;
   logic [DW-1:0]   seg_data_p0, trunc_data_p0;
   logic            acc_seg, acc_trunc, pop, drop;
   logic [1:0]      n_acc;

   function automatic logic [AW:0] seg_width(input logic [AW-1:0] s, input logic [AW-1:0] e);
      return {1'b0, e} - {1'b0, s} + (AW+1)'(1);
   endfunction

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {7'd0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   // p0: strobe decode; frame_end is applied on top of the strobe outcome of the same cycle
   assign last_eff = det_valid ? addr : last_p1;

   always_comb begin
      state_nxt     = state;
      start_nxt     = start_p1;
      seg_vld_p0    = 1'b0;
      seg_data_p0   = '0;
      trunc_vld_p0  = 1'b0;
      trunc_data_p0 = '0;
      case (state)
         IDLE: begin
            if (det_valid && target_start && target_end) begin
               seg_vld_p0  = 1'b1;
               seg_data_p0 = {1'b0, addr, addr};
            end else if (det_valid && target_start) begin
               start_nxt = addr;
               state_nxt = OPEN;
            end
         end
         OPEN: begin
            if (det_valid && target_end) begin
               seg_vld_p0  = 1'b1;
               seg_data_p0 = {1'b0, addr, start_p1};
               if (target_start) start_nxt = addr;
               else              state_nxt = IDLE;
            end else if (det_valid && target_start) begin
               start_nxt = addr;
            end
         end
      endcase
      if (frame_end) begin
         if (state_nxt == OPEN) begin
            trunc_vld_p0  = 1'b1;
            trunc_data_p0 = {1'b1, last_eff, start_nxt};
         end
         state_nxt = IDLE;
      end
   end

   // Truncated segments bypass the width filter; the filter folds away when disabled.
   assign keep_p0 = seg_vld_p0 &&
                    (!MIN_EN || (seg_width(seg_data_p0[AW-1:0], seg_data_p0[DW-2:AW]) >= MIN_W));

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
   assign pop   = rd_en && !empty;
   assign used  = wr_ptr - rd_ptr;
   assign free  = DEPTH_C - {1'b0, used} + (PW+1)'(pop);

   // Up to two entries per cycle (closing segment then truncated one); a pop frees a slot.
   assign acc_seg   = keep_p0 && (free != '0);
   assign acc_trunc = trunc_vld_p0 && (free > (PW+1)'(acc_seg));
   assign drop      = (keep_p0 && !acc_seg) || (trunc_vld_p0 && !acc_trunc);
   assign n_acc     = {1'b0, acc_seg} + {1'b0, acc_trunc};
   assign wr_idx    = wr_ptr[PW-2:0];
   assign wr_idx_b  = wr_idx + (PW-1)'(acc_seg);

   // p1: control registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         seg_count  <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else if (clr) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         seg_count  <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         wr_ptr     <= wr_ptr + PW'(n_acc);
         rd_ptr     <= rd_ptr + PW'(pop);
         seg_count  <= sat_add(frame_done ? 8'd0 : seg_count, n_acc);
         overflow   <= overflow | drop;
         frame_done <= frame_end;
      end
   end

   // p1: data registers and FIFO storage
   always_ff @(posedge clk) begin
      start_p1 <= start_nxt;
      if (det_valid) last_p1 <= addr;
      if (acc_seg)   mem[wr_idx]   <= seg_data_p0;
      if (acc_trunc) mem[wr_idx_b] <= trunc_data_p0;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr[PW-2:0]];

endmodule
